// File: rtl/bcd_to_bin_if.sv
// Request/response bundle for the 4-digit BCD to 14-bit binary converter.
// The master drives the digits and start; the slave returns status and the result.
interface bcd_to_bin_if;
    logic        start;
    logic [3:0]  thousands;
    logic [3:0]  hundreds;
    logic [3:0]  tens;
    logic [3:0]  ones;
    logic        busy;
    logic        done;
    logic [13:0] bin;
    logic        invalid;

    modport master (
        output start,
        output thousands,
        output hundreds,
        output tens,
        output ones,
        input  busy,
        input  done,
        input  bin,
        input  invalid
    );

    modport slave (
        input  start,
        input  thousands,
        input  hundreds,
        input  tens,
        input  ones,
        output busy,
        output done,
        output bin,
        output invalid
    );
endinterface

// File: rtl/bcd_to_bin.sv
// Sequential BCD to binary converter using reverse double-dabble: one shift/correct
// step per cycle, 14 steps per conversion, result and validity flag registered on done.
module bcd_to_bin (
    input  logic         clk,
    input  logic         rst_n,
    bcd_to_bin_if.slave  bus
);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    localparam logic [3:0] LastStep = 4'd13;

    state_e      r_state;
    logic [15:0] r_bcd;
    logic [13:0] r_bin_work;
    logic [3:0]  r_cnt;
    logic        r_busy;
    logic        r_done;
    logic [13:0] r_bin;
    logic        r_invalid;

    state_e      w_state_next;
    logic [15:0] w_bcd_next;
    logic [13:0] w_bin_work_next;
    logic [3:0]  w_cnt_next;
    logic        w_busy_next;
    logic        w_done_next;
    logic [13:0] w_bin_next;
    logic        w_invalid_next;

    logic        w_digit_bad;
    logic [29:0] w_shift;
    logic [15:0] w_step_bcd;
    logic [13:0] w_step_bin;

    assign w_digit_bad = (bus.thousands > 4'd9) || (bus.hundreds > 4'd9) ||
                         (bus.tens > 4'd9) || (bus.ones > 4'd9);

    // The LSB of the BCD word falls into the binary word's MSB on each shift.
    assign w_shift    = {r_bcd, r_bin_work} >> 1;
    assign w_step_bin = w_shift[13:0];

    always_comb begin
        w_step_bcd = w_shift[29:14];
        for (int i = 0; i < 4; i++) begin
            if (w_shift[14 + 4 * i + 3]) begin
                w_step_bcd[4 * i +: 4] = w_shift[14 + 4 * i +: 4] - 4'd3;
            end
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_bcd_next      = r_bcd;
        w_bin_work_next = r_bin_work;
        w_cnt_next      = r_cnt;
        w_busy_next     = r_busy;
        w_done_next     = 1'b0;
        w_bin_next      = r_bin;
        w_invalid_next  = r_invalid;

        unique case (r_state)
            StIdle: begin
                if (bus.start) begin
                    if (w_digit_bad) begin
                        w_bin_next     = 14'd0;
                        w_invalid_next = 1'b1;
                        w_done_next    = 1'b1;
                    end else begin
                        w_bcd_next      = {bus.thousands, bus.hundreds, bus.tens, bus.ones};
                        w_bin_work_next = 14'd0;
                        w_cnt_next      = 4'd0;
                        w_busy_next     = 1'b1;
                        w_state_next    = StShift;
                    end
                end
            end
            StShift: begin
                w_bcd_next      = w_step_bcd;
                w_bin_work_next = w_step_bin;
                w_cnt_next      = r_cnt + 4'd1;
                if (r_cnt == LastStep) begin
                    w_bin_next     = w_step_bin;
                    w_invalid_next = 1'b0;
                    w_done_next    = 1'b1;
                    w_busy_next    = 1'b0;
                    w_state_next   = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_bcd      <= 16'd0;
            r_bin_work <= 14'd0;
            r_cnt      <= 4'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_bin      <= 14'd0;
            r_invalid  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_bcd      <= w_bcd_next;
            r_bin_work <= w_bin_work_next;
            r_cnt      <= w_cnt_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
            r_bin      <= w_bin_next;
            r_invalid  <= w_invalid_next;
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.bin     = r_bin;
    assign bus.invalid = r_invalid;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Scoreboard bench for bcd_to_bin: stimulus pushes expected results with their due cycle,
// a monitor pops and checks them whenever done is seen.
module tb_bcd_to_bin;

    typedef struct {
        logic [13:0] bin;
        logic        inv;
        int          due;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    exp_t q[$];
    exp_t e;
    int   bcnt;

    bcd_to_bin_if bus ();

    bcd_to_bin dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                e = q.pop_front();
                chk("bin", int'(bus.bin), int'(e.bin));
                chk("invalid", int'(bus.invalid), int'(e.inv));
                chk("latency_cycle", cyc, e.due);
                chk("busy_with_done", int'(bus.busy), 0);
            end
        end
    end

    task automatic issue(input logic [3:0] th, input logic [3:0] hu, input logic [3:0] te,
                         input logic [3:0] on, input logic push, input logic [13:0] eb,
                         input logic ei, input int lat);
        @(negedge clk);
        bus.thousands = th;
        bus.hundreds  = hu;
        bus.tens      = te;
        bus.ones      = on;
        bus.start     = 1'b1;
        if (push) q.push_back('{eb, ei, cyc + 1 + lat});
        @(negedge clk);
        bus.start     = 1'b0;
    endtask

    // Counts busy samples from the current negedge until the scoreboard drains.
    task automatic drain(output int busy_cnt);
        busy_cnt = int'(bus.busy);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            busy_cnt += int'(bus.busy);
            if (q.size() == 0) return;
        end
        checks++;
        errors++;
        $display("FAIL drain_timeout actual=%0d required=0 pending", q.size());
        q.delete();
    endtask

    initial begin
        cyc           = 0;
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.thousands = 4'd0;
        bus.hundreds  = 4'd0;
        bus.tens      = 4'd0;
        bus.ones      = 4'd0;

        repeat (3) @(negedge clk);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_bin", int'(bus.bin), 0);
        chk("rst_invalid", int'(bus.invalid), 0);
        rst_n = 1'b1;

        // 9999: busy for 14 cycles; digits wiggle mid-conversion without effect.
        issue(4'd9, 4'd9, 4'd9, 4'd9, 1'b1, 14'd9999, 1'b0, 14);
        chk("busy_after_accept", int'(bus.busy), 1);
        bus.thousands = 4'd1;
        bus.ones      = 4'd3;
        drain(bcnt);
        chk("busy_cycles_9999", bcnt, 14);

        issue(4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 14'd1234, 1'b0, 14);
        drain(bcnt);
        chk("busy_cycles_1234", bcnt, 14);
        repeat (4) @(negedge clk);
        chk("bin_hold", int'(bus.bin), 1234);

        issue(4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 14'd0, 1'b0, 14);
        drain(bcnt);

        // Invalid digit: immediate done, no busy.
        issue(4'd0, 4'd5, 4'hA, 4'd1, 1'b1, 14'd0, 1'b1, 0);
        drain(bcnt);
        chk("busy_cycles_invalid", bcnt, 0);

        // Second start during SHIFT must be ignored.
        issue(4'd4, 4'd3, 4'd2, 4'd1, 1'b1, 14'd4321, 1'b0, 14);
        repeat (3) @(negedge clk);
        issue(4'd7, 4'd7, 4'd7, 4'd7, 1'b0, 14'd0, 1'b0, 0);
        drain(bcnt);
        repeat (3) @(negedge clk);

        // Start held high: done pulses every 15 cycles.
        @(negedge clk);
        bus.thousands = 4'd0;
        bus.hundreds  = 4'd0;
        bus.tens      = 4'd0;
        bus.ones      = 4'd7;
        bus.start     = 1'b1;
        q.push_back('{14'd7, 1'b0, cyc + 15});
        q.push_back('{14'd7, 1'b0, cyc + 30});
        q.push_back('{14'd7, 1'b0, cyc + 45});
        repeat (45) @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        #1;
        chk("held_start_drained", q.size(), 0);
        q.delete();

        // Reset mid-conversion: everything clears at once, no done follows.
        issue(4'd8, 4'd8, 4'd8, 4'd8, 1'b0, 14'd0, 1'b0, 0);
        repeat (4) @(negedge clk);
        chk("pre_abort_busy", int'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_done", int'(bus.done), 0);
        chk("abort_bin", int'(bus.bin), 0);
        chk("abort_invalid", int'(bus.invalid), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("no_done_after_abort_bin", int'(bus.bin), 0);

        // First start after reset release is accepted normally.
        issue(4'd0, 4'd0, 4'd4, 4'd2, 1'b1, 14'd42, 1'b0, 14);
        drain(bcnt);
        chk("busy_cycles_42", bcnt, 14);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_to_bin.md
BCD_TO_BIN -- requirements
Module: bcd_to_bin

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 4 BCD digits in and 14 binary bits out.
REQ-002 clk  input  1  single clock; all state SHALL change on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request pulse; sampled on the rising edge of clk.
REQ-005 thousands  input  4  BCD digit, 10^3 weight; sampled only when start is accepted.
REQ-006 hundreds  input  4  BCD digit, 10^2 weight; sampled only when start is accepted.
REQ-007 tens  input  4  BCD digit, 10^1 weight; sampled only when start is accepted.
REQ-008 ones  input  4  BCD digit, 10^0 weight; sampled only when start is accepted.
REQ-009 busy  output  1  high while a conversion is in progress.
REQ-010 done  output  1  one-cycle pulse marking that bin and invalid are updated.
REQ-011 bin  output  14  registered binary result, range 0..9999.
REQ-012 invalid  output  1  registered flag: the last accepted request held a digit greater than 9.

Function
REQ-013 The FSM SHALL have exactly two states, IDLE and SHIFT.
REQ-014 In IDLE, start=1 SHALL be accepted on that edge:
- the four digits are captured into a 16-bit BCD work register;
- the 14-bit binary work register is cleared;
- the shift counter is cleared;
- busy goes to 1 and the state moves to SHIFT.
REQ-015 If any captured digit is greater than 9, the block SHALL not enter SHIFT. It SHALL stay in IDLE, load bin=0 and invalid=1, and pulse done on the same edge, giving a 1-cycle latency.
REQ-016 In SHIFT, each cycle SHALL perform one reverse double-dabble step:
- shift the 30-bit concatenation {BCD work, binary work} right by 1;
- then subtract 3 from every BCD nibble whose value is 8 or more.
REQ-017 The block SHALL perform exactly 14 SHIFT steps. On the 14th step edge it SHALL:
- load bin from the binary work register and set invalid=0;
- assert done;
- deassert busy and return to IDLE.
REQ-018 For a start accepted at edge N with valid digits:
- busy SHALL be high after edges N..N+13;
- done SHALL be high only in the cycle following edge N+14, so latency is 14 cycles.
REQ-019 done SHALL be high for exactly one cycle per accepted request and SHALL never be asserted while busy=1.
REQ-020 start SHALL be ignored while in SHIFT; the captured digits and the in-flight conversion SHALL be unaffected.
REQ-021 start high in the same cycle that done is high SHALL be accepted, because the state is IDLE by then, allowing back-to-back conversions.
REQ-022 bin and invalid SHALL hold their value between done pulses and SHALL change only on a done edge.
REQ-023 Changes on the digit inputs SHALL have no effect except on the edge where start is accepted.
REQ-024 All arithmetic SHALL be unsigned. The nibble subtract SHALL never underflow, since only nibbles of 8 or more are corrected. The binary result SHALL never exceed 14 bits.

Reset
REQ-025 While rst_n=0, the following SHALL hold regardless of clk:
- state=IDLE, busy=0, done=0, bin=0, invalid=0;
- both work registers and the counter are cleared.
REQ-026 Assertion of rst_n during SHIFT SHALL abort the conversion immediately, with no done pulse and no bin update.
REQ-027 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-028 Digits 9,9,9,9 with a start pulse -> busy for 14 cycles, then done with bin=9999 (0x270F) and invalid=0.
REQ-029 Digits 1,2,3,4 -> bin=1234 (0x04D2). Digits 0,0,0,0 -> bin=0. Both complete with 14-cycle latency.
REQ-030 Digits 0,5,0xA,1 -> done one cycle after start, with bin=0, invalid=1, busy never high.
REQ-031 Start at 4,3,2,1, then start again at 7,7,7,7 five cycles later -> the second start is ignored and the result is 4321 only.
REQ-032 Start held high continuously with digits 0,0,0,7 -> one conversion per 15 cycles, done pulses spaced exactly 15 cycles apart, each with bin=7.
REQ-033 Start at 8,8,8,8, then drive rst_n low at cycle 6 -> busy, done, bin and invalid all go 0 immediately, and no done pulse follows.
